// File: rtl/coldstorage_pkg.sv
// Shared constants, parser state encoding and message struct for the cold-storage UART command path.
package coldstorage_pkg;

  localparam logic [7:0] CMD_L   = 8'h4C;
  localparam logic [7:0] CMD_A   = 8'h41;
  localparam logic [7:0] CMD_B   = 8'h42;
  localparam logic [7:0] CMD_C   = 8'h43;
  localparam logic [7:0] CMD_D   = 8'h44;
  localparam logic [7:0] CHR_0   = 8'h30;
  localparam logic [7:0] CHR_9   = 8'h39;
  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_ACK = 8'h4B;
  localparam logic [7:0] CHR_NAK = 8'h45;

  // Controller refreshes the LCD every 0.5 s; the hold must outlast one interval plus a cycle.
  localparam int LCD_INTERVAL_CYCLES = 50_000_000;
  localparam int HOLD_CYCLES_DEF     = LCD_INTERVAL_CYCLES + 2;
  localparam int TIMEOUT_CYCLES_DEF  = 10_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_CMD = 2'd1,
    GOT_V0  = 2'd2,
    GOT_V1  = 2'd3
  } parse_state_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] v0;
    logic [7:0] v1;
  } cmd_msg_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_L) || (b == CMD_A) || (b == CMD_B) || (b == CMD_C) || (b == CMD_D);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CHR_0) && (b <= CHR_9);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == CHR_CR) || (b == CHR_LF);
  endfunction

endpackage

// File: rtl/msg_hold_timer.sv
// Loadable down-counter that stretches a one-cycle accept into a level lasting HOLD_CYCLES clocks.
module msg_hold_timer
  import coldstorage_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic active
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_active;

  // A load always wins over expiry, so back-to-back accepts keep the level solid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_cnt    <= CW'(HOLD_CYCLES - 1);
      r_active <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt    <= r_cnt - CW'(1);
    end else begin
      r_active <= 1'b0;
    end
  end

  assign active = r_active;

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into <cmd><digit><digit><CR|LF> commands for the logic controller.
// Define UART_CMD_ECHO_EN to add a one-entry 'K'/'E' status echo on tx_data/tx_valid/tx_ready.
module uart_cmd_parser
  import coldstorage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       chr_cmd,
  output logic [7:0]       chr_val0,
  output logic [7:0]       chr_val1,
  output logic             rx_msg_done,
  output logic             msg_pulse,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
`ifdef UART_CMD_ECHO_EN
  ,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  parse_state_t     r_state, w_next;
  cmd_msg_t         r_shadow, r_out;
  logic             r_busy, r_pulse;
  logic [ERR_W-1:0] r_err;
  logic [TW-1:0]    r_to_cnt;

  logic w_ld_cmd, w_ld_v0, w_ld_v1, w_accept, w_err, w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ld_cmd  = 1'b0;
    w_ld_v0   = 1'b0;
    w_ld_v1   = 1'b0;
    w_accept  = 1'b0;
    w_err     = 1'b0;
    w_timeout = 1'b0;
    if (rx_valid) begin
      case (r_state)
        IDLE: begin
          if (is_cmd(rx_data)) begin
            w_ld_cmd = 1'b1;
            w_next   = GOT_CMD;
          end
        end
        GOT_CMD: begin
          if (is_digit(rx_data)) begin
            w_ld_v0 = 1'b1;
            w_next  = GOT_V0;
          end else begin
            w_err = 1'b1;
          end
        end
        GOT_V0: begin
          if (is_digit(rx_data)) begin
            w_ld_v1 = 1'b1;
            w_next  = GOT_V1;
          end else begin
            w_err = 1'b1;
          end
        end
        GOT_V1: begin
          if (is_term(rx_data)) begin
            w_accept = 1'b1;
            w_next   = IDLE;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
      // An offending cmd char starts a fresh message instead of being thrown away.
      if (w_err) begin
        if (is_cmd(rx_data)) begin
          w_ld_cmd = 1'b1;
          w_next   = GOT_CMD;
        end else begin
          w_next   = IDLE;
        end
      end
    end else if (r_state != IDLE && r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      w_timeout = 1'b1;
      w_next    = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (rx_valid || r_state == IDLE || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '{cmd: CHR_0, v0: CHR_0, v1: CHR_0};
      r_out    <= '{cmd: CHR_0, v0: CHR_0, v1: CHR_0};
      r_busy   <= 1'b0;
      r_pulse  <= 1'b0;
      r_err    <= '0;
    end else begin
      if (w_ld_cmd) r_shadow.cmd <= rx_data;
      if (w_ld_v0)  r_shadow.v0  <= rx_data;
      if (w_ld_v1)  r_shadow.v1  <= rx_data;
      // Shadow still holds the full message while the terminator is being sampled.
      if (w_accept) r_out <= r_shadow;
      r_pulse <= w_accept;
      r_busy  <= (w_next != IDLE);
      if ((w_err || w_timeout) && (r_err != '1)) r_err <= r_err + ERR_W'(1);
    end
  end

  msg_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_accept),
    .active(rx_msg_done)
  );

  assign chr_cmd   = r_out.cmd;
  assign chr_val0  = r_out.v0;
  assign chr_val1  = r_out.v1;
  assign msg_pulse = r_pulse;
  assign busy      = r_busy;
  assign err_count = r_err;

`ifdef UART_CMD_ECHO_EN
  logic [7:0] r_tx_data;
  logic       r_tx_valid;

  // Single slot: the newest status overwrites anything not yet taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else if (w_accept) begin
      r_tx_data  <= CHR_ACK;
      r_tx_valid <= 1'b1;
    end else if (w_err || w_timeout) begin
      r_tx_data  <= CHR_NAK;
      r_tx_valid <= 1'b1;
    end else if (r_tx_valid && tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed, table-driven bench for uart_cmd_parser with short hold/timeout values.
module tb_uart_cmd_parser;

  localparam int HOLD = 20;
  localparam int TOUT = 50;

  logic       clk, rst_n, rx_valid, tx_ready;
  logic [7:0] rx_data;
  logic [7:0] chr_cmd, chr_val0, chr_val1, err_count;
  logic       rx_msg_done, msg_pulse, busy;
`ifdef UART_CMD_ECHO_EN
  logic [7:0] tx_data;
  logic       tx_valid;
`endif

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(TOUT),
    .HOLD_CYCLES   (HOLD),
    .ERR_W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .chr_cmd    (chr_cmd),
    .chr_val0   (chr_val0),
    .chr_val1   (chr_val1),
    .rx_msg_done(rx_msg_done),
    .msg_pulse  (msg_pulse),
    .busy       (busy),
    .err_count  (err_count)
`ifdef UART_CMD_ECHO_EN
    ,
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    #3;
  endtask

  task automatic chk_out(input string nm, input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
    chk({nm, ".cmd"}, chr_cmd, c);
    chk({nm, ".v0"}, chr_val0, a);
    chk({nm, ".v1"}, chr_val1, b);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       busy;
    logic [7:0] err;
    logic [7:0] cmd;
    logic [7:0] v0;
    logic [7:0] v1;
    logic       pulse;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] d, input logic b, input logic [7:0] e,
                              input logic [7:0] c, input logic [7:0] a, input logic [7:0] v,
                              input logic p);
    vec_t r;
    r.d = d; r.busy = b; r.err = e; r.cmd = c; r.v0 = a; r.v1 = v; r.pulse = p;
    return r;
  endfunction

  logic mon_en = 1'b0;
  logic mon_drop = 1'b0;
  always @(negedge clk) if (mon_en && !rx_msg_done) mon_drop <= 1'b1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;

    // "A25\n", "A2X" + "C40\r", "D0" + "L11\n", idle noise, resync from GOT_V1, digit/CR errors
    tbl.push_back(mk("A",   1, 0, 8'h30, 8'h30, 8'h30, 0));
    tbl.push_back(mk("2",   1, 0, 8'h30, 8'h30, 8'h30, 0));
    tbl.push_back(mk("5",   1, 0, 8'h30, 8'h30, 8'h30, 0));
    tbl.push_back(mk(8'h0A, 0, 0, 8'h41, 8'h32, 8'h35, 1));
    tbl.push_back(mk("A",   1, 0, 8'h41, 8'h32, 8'h35, 0));
    tbl.push_back(mk("2",   1, 0, 8'h41, 8'h32, 8'h35, 0));
    tbl.push_back(mk("X",   0, 1, 8'h41, 8'h32, 8'h35, 0));
    tbl.push_back(mk("C",   1, 1, 8'h41, 8'h32, 8'h35, 0));
    tbl.push_back(mk("4",   1, 1, 8'h41, 8'h32, 8'h35, 0));
    tbl.push_back(mk("0",   1, 1, 8'h41, 8'h32, 8'h35, 0));
    tbl.push_back(mk(8'h0D, 0, 1, 8'h43, 8'h34, 8'h30, 1));
    tbl.push_back(mk("D",   1, 1, 8'h43, 8'h34, 8'h30, 0));
    tbl.push_back(mk("0",   1, 1, 8'h43, 8'h34, 8'h30, 0));
    tbl.push_back(mk("L",   1, 2, 8'h43, 8'h34, 8'h30, 0));
    tbl.push_back(mk("1",   1, 2, 8'h43, 8'h34, 8'h30, 0));
    tbl.push_back(mk("1",   1, 2, 8'h43, 8'h34, 8'h30, 0));
    tbl.push_back(mk(8'h0A, 0, 2, 8'h4C, 8'h31, 8'h31, 1));
    tbl.push_back(mk("Z",   0, 2, 8'h4C, 8'h31, 8'h31, 0));
    tbl.push_back(mk(8'h0D, 0, 2, 8'h4C, 8'h31, 8'h31, 0));
    tbl.push_back(mk("5",   0, 2, 8'h4C, 8'h31, 8'h31, 0));
    tbl.push_back(mk("B",   1, 2, 8'h4C, 8'h31, 8'h31, 0));
    tbl.push_back(mk("1",   1, 2, 8'h4C, 8'h31, 8'h31, 0));
    tbl.push_back(mk("2",   1, 2, 8'h4C, 8'h31, 8'h31, 0));
    tbl.push_back(mk("B",   1, 3, 8'h4C, 8'h31, 8'h31, 0));
    tbl.push_back(mk("3",   1, 3, 8'h4C, 8'h31, 8'h31, 0));
    tbl.push_back(mk("4",   1, 3, 8'h4C, 8'h31, 8'h31, 0));
    tbl.push_back(mk(8'h0A, 0, 3, 8'h42, 8'h33, 8'h34, 1));
    tbl.push_back(mk("a",   0, 3, 8'h42, 8'h33, 8'h34, 0));
    tbl.push_back(mk("C",   1, 3, 8'h42, 8'h33, 8'h34, 0));
    tbl.push_back(mk("1",   1, 3, 8'h42, 8'h33, 8'h34, 0));
    tbl.push_back(mk("2",   1, 3, 8'h42, 8'h33, 8'h34, 0));
    tbl.push_back(mk("3",   0, 4, 8'h42, 8'h33, 8'h34, 0));
    tbl.push_back(mk("A",   1, 4, 8'h42, 8'h33, 8'h34, 0));
    tbl.push_back(mk(8'h0D, 0, 5, 8'h42, 8'h33, 8'h34, 0));

    #7;
    chk_out("rst", 8'h30, 8'h30, 8'h30);
    chk("rst.done", rx_msg_done, 0);
    chk("rst.pulse", msg_pulse, 0);
    chk("rst.busy", busy, 0);
    chk("rst.err", err_count, 0);
    #8;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      send_byte(tbl[i].d);
      chk($sformatf("v%0d.busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d.err", i), err_count, tbl[i].err);
      chk($sformatf("v%0d.cmd", i), chr_cmd, tbl[i].cmd);
      chk($sformatf("v%0d.v0", i), chr_val0, tbl[i].v0);
      chk($sformatf("v%0d.v1", i), chr_val1, tbl[i].v1);
      chk($sformatf("v%0d.pulse", i), msg_pulse, tbl[i].pulse);
    end

    // Hold length: rx_msg_done high for exactly HOLD cycles, pulse for one.
    do_reset();
    send_byte("A"); send_byte("2"); send_byte("5"); send_byte(8'h0A);
    chk("hold.pulse", msg_pulse, 1);
    chk("hold.done0", rx_msg_done, 1);
    cnt = 0;
    while (rx_msg_done === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
      if (cnt == 1) chk("hold.pulse_1cyc", msg_pulse, 0);
    end
    chk("hold.len", cnt, HOLD);

    // Timeout boundary: still busy one cycle before expiry, idle right after.
    send_byte("B"); send_byte("1");
    repeat (TOUT - 1) @(posedge clk);
    #1;
    chk("to.busy_before", busy, 1);
    chk("to.err_before", err_count, 0);
    @(posedge clk);
    #1;
    chk("to.busy_after", busy, 0);
    chk("to.err_after", err_count, 1);
    chk_out("to.out", 8'h41, 8'h32, 8'h35);
    send_byte(8'h0A);
    chk("to.lf_busy", busy, 0);
    chk("to.lf_err", err_count, 1);
    chk("to.lf_pulse", msg_pulse, 0);

    // Byte arriving in the expiry cycle is processed, no timeout.
    send_byte("B"); send_byte("1");
    repeat (TOUT - 2) @(posedge clk);
    send_byte("2");
    chk("toedge.busy", busy, 1);
    chk("toedge.err", err_count, 1);
    send_byte(8'h0D);
    chk("toedge.pulse", msg_pulse, 1);
    chk_out("toedge.out", 8'h42, 8'h31, 8'h32);

    // Two accepts 10 cycles apart: the level never drops, then lasts HOLD after the second.
    repeat (30) @(posedge clk);
    send_byte("A"); send_byte("2"); send_byte("5"); send_byte(8'h0A);
    chk("two.pulse1", msg_pulse, 1);
    mon_drop = 1'b0;
    mon_en   = 1'b1;
    repeat (2) @(posedge clk);
    send_byte("B"); send_byte("1"); send_byte("2"); send_byte(8'h0D);
    mon_en = 1'b0;
    chk("two.pulse2", msg_pulse, 1);
    chk("two.nodrop", mon_drop, 0);
    chk_out("two.out", 8'h42, 8'h31, 8'h32);
    cnt = 0;
    while (rx_msg_done === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("two.len", cnt, HOLD);
    send_byte(8'h0A);
    chk("two.lf_err", err_count, 1);
    chk("two.lf_busy", busy, 0);

    // Error counter saturation.
    for (int k = 0; k < 300; k++) begin
      send_byte("A");
      send_byte("X");
    end
    chk("sat.err", err_count, 255);
    chk_out("sat.out", 8'h42, 8'h31, 8'h32);

    // Asynchronous reset in the middle of a message, with rx_msg_done high.
    send_byte("A"); send_byte("2"); send_byte("5"); send_byte(8'h0A);
    send_byte("C"); send_byte("1");
    chk("mid.done_pre", rx_msg_done, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("mid.rst", 8'h30, 8'h30, 8'h30);
    chk("mid.done", rx_msg_done, 0);
    chk("mid.busy", busy, 0);
    chk("mid.err", err_count, 0);
    #2;
    rst_n = 1'b1;
    send_byte("2"); send_byte(8'h0D);
    chk("mid.after_busy", busy, 0);
    chk("mid.after_pulse", msg_pulse, 0);
    chk_out("mid.after", 8'h30, 8'h30, 8'h30);

`ifdef UART_CMD_ECHO_EN
    do_reset();
    chk("echo.rst_valid", tx_valid, 0);
    chk("echo.rst_data", tx_data, 0);
    send_byte("A"); send_byte("X");
    chk("echo.nak_valid", tx_valid, 1);
    chk("echo.nak_data", tx_data, 8'h45);
    send_byte("A"); send_byte("1"); send_byte("2"); send_byte(8'h0A);
    chk("echo.ack_valid", tx_valid, 1);
    chk("echo.ack_data", tx_data, 8'h4B);
    @(posedge clk);
    #1;
    chk("echo.held", tx_valid, 1);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    chk("echo.drained", tx_valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Frames the received UART byte stream into 3-character threshold/LED commands: cmd char, two ASCII digits, then CR/LF.
- Sits between the UART byte receiver and the logic controller.
- Drives chr_cmd, chr_val0, chr_val1 and rx_msg_done.
- Holds rx_msg_done long enough that a consumer sampling only on its 0.5 s tick always sees each message.

Parameters:
- TIMEOUT_CYCLES, 10_000_000: maximum idle clocks between bytes inside a message before the message is abandoned.
- HOLD_CYCLES, 50_000_002: clocks rx_msg_done stays high after a valid message. This must exceed the consumer update interval + 1.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- chr_cmd  out  8  latched command char ('L','A','B','C','D')
- chr_val0  out  8  latched first digit (ASCII)
- chr_val1  out  8  latched second digit (ASCII)
- rx_msg_done  out  1  stretched message-valid level
- msg_pulse  out  1  one-cycle strobe per accepted message
- busy  out  1  high when the parser state is not IDLE
- err_count  out  ERR_W  saturating count of rejected messages

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - chr_cmd = chr_val0 = chr_val1 = 8'h30.
  - rx_msg_done = 0, msg_pulse = 0, busy = 0, err_count = 0.
  - Hold counter and timeout counter = 0.
- FSM states: IDLE, GOT_CMD, GOT_V0, GOT_V1. Transitions occur only on cycles with rx_valid=1.
- IDLE:
  - A cmd char in {0x4C,0x41,0x42,0x43,0x44} is stored in the shadow register; go to GOT_CMD.
  - Any other byte, including CR/LF, is ignored silently. This makes CRLF and noise harmless.
- GOT_CMD:
  - Digit 0x30-0x39 goes to shadow v0; go to GOT_V0.
- GOT_V0:
  - Digit goes to shadow v1; go to GOT_V1.
- GOT_V1:
  - Terminator 0x0D or 0x0A: accept the message; go to IDLE.
- Error in GOT_CMD, GOT_V0 or GOT_V1 (unexpected byte):
  - err_count increments (saturates at all-ones).
  - If the offending byte is itself a cmd char, it is stored and the state is GOT_CMD (resync).
  - Otherwise the state is IDLE.
- Timeout:
  - The timeout counter clears on every rx_valid and counts while state != IDLE.
  - Reaching TIMEOUT_CYCLES-1 without a byte: state = IDLE, err_count increments.
  - rx_valid in the same cycle as expiry: the byte is processed normally and no timeout occurs.
- Accept (terminator seen in cycle N):
  - In cycle N+1, chr_cmd/chr_val0/chr_val1 take the shadow values.
  - msg_pulse = 1 for exactly that cycle.
  - rx_msg_done = 1 and the hold counter loads HOLD_CYCLES-1.
- rx_msg_done:
  - Stays high while the hold counter > 0 and drops the cycle after it reaches 0.
  - A new accept during the hold reloads the counter; rx_msg_done stays high continuously.
  - If an accept and counter expiry occur in the same cycle, the accept wins.
- Output stability: chr_* outputs change only on accept. A partial or erroneous message never disturbs them.
- busy is registered: busy = (state != IDLE).
- Reset mid-message discards the shadow registers; the outputs return to their reset values immediately.

Optional Feature:
- Macro: UART_CMD_ECHO_EN.
- When defined, the block adds ports tx_data (out, 8), tx_valid (out, 1) and tx_ready (in, 1).
  - On accept it queues 'K' (0x4B).
  - On each error or timeout it queues 'E' (0x45).
  - There is a one-entry buffer: tx_valid is held until a cycle with tx_ready=1, then cleared the next cycle.
  - A new response while one is pending overwrites tx_data (latest status wins).
  - Reset value: tx_valid = 0, tx_data = 0.
- When undefined, these ports and this logic are absent.
- Parser behaviour is identical in both cases.

Decomposition:
- Shared package coldstorage_pkg holds:
  - the ASCII constants: CMD_L/A/B/C/D, CHR_0, CHR_9, CHR_CR, CHR_LF, CHR_ACK 'K', CHR_NAK 'E';
  - the parser state encoding;
  - the default HOLD_CYCLES, tied to the controller's LCD interval constant.
- One sub-module, msg_hold_timer: a loadable down-counter producing the stretched rx_msg_done level (inputs load, outputs active).

Test Plan:
- Bytes "A25\n" → cycle after '\n': chr_cmd=0x41, val0=0x32, val1=0x35, msg_pulse one cycle, rx_msg_done high for exactly HOLD_CYCLES cycles (use HOLD_CYCLES=20 in the bench).
- Bytes "A2X" then "C40\r" → err_count=1 after 'X', outputs unchanged; then chr_cmd=0x43, val0/val1="40".
- Bytes "B1" then silence for TIMEOUT_CYCLES (bench value 50) → busy falls, err_count=1, outputs unchanged; "\n" afterwards is ignored.
- Bytes "D0" then "L11\n" → resync: err_count=1, accepted chr_cmd=0x4C, val="11".
- Two messages 10 cycles apart with HOLD_CYCLES=20 → rx_msg_done never drops and stays high 20 cycles after the second accept; "\r\n" produces no extra error.
- Drive 300 bad messages → err_count saturates at 255. Assert rst_n mid-message → all outputs return to reset values asynchronously. Under UART_CMD_ECHO_EN with tx_ready low: the pending 'E' is overwritten by 'K'.
